// File: rtl/sreg_addr_ctrl_if.sv
// sreg_addr_ctrl_if: run control, schedule configuration and memory-port signals of sreg_addr_ctrl.
interface sreg_addr_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              clk_en;
    logic              start;
    logic [CNT_W-1:0]  cfg_wr_start, cfg_rd_start;
    logic [ADDR_W-1:0] cfg_wr_ext0, cfg_wr_ext1, cfg_rd_ext0, cfg_rd_ext1;
    logic [ADDR_W-1:0] cfg_wr_str0, cfg_wr_str1, cfg_rd_str0, cfg_rd_str1;
    logic [ADDR_W-1:0] cfg_wr_off, cfg_rd_off;
    logic              wen_0, ren_0, busy, done, hazard_err;
    logic [ADDR_W-1:0] write_addr_0, read_addr_0;
    modport master (
        output clk_en, start, cfg_wr_start, cfg_rd_start,
        output cfg_wr_ext0, cfg_wr_ext1, cfg_rd_ext0, cfg_rd_ext1,
        output cfg_wr_str0, cfg_wr_str1, cfg_rd_str0, cfg_rd_str1, cfg_wr_off, cfg_rd_off,
        input  wen_0, write_addr_0, ren_0, read_addr_0, busy, done, hazard_err
    );
    modport slave (
        input  clk_en, start, cfg_wr_start, cfg_rd_start,
        input  cfg_wr_ext0, cfg_wr_ext1, cfg_rd_ext0, cfg_rd_ext1,
        input  cfg_wr_str0, cfg_wr_str1, cfg_rd_str0, cfg_rd_str1, cfg_wr_off, cfg_rd_off,
        output wen_0, write_addr_0, ren_0, read_addr_0, busy, done, hazard_err
    );
endinterface

// File: rtl/sreg_addr_ctrl.sv
// sreg_addr_ctrl: static-schedule write/read 2-D address generator for a line-buffer memory.
// Optional occupancy checking is enabled by defining SREG_HAZARD_CHECK_EN.
module sreg_addr_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    sreg_addr_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  T_MAX = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state, state_d;
    logic [CNT_W-1:0]  t, tn;
    logic [ADDR_W-1:0] sh_e0 [2], sh_e1 [2], sh_s0 [2], sh_s1 [2], sh_off [2];
    logic [CNT_W-1:0]  sh_st [2];
    logic [ADDR_W-1:0] e0 [2], e1 [2], s0 [2], s1 [2], off [2];
    logic [CNT_W-1:0]  st [2];
    logic [ADDR_W-1:0] ci [2], cj [2], addr [2], rbase [2];
    logic [1:0]        act, fin, last, fin_now;
    logic              idle, accept, wen, ren;
    // Index 0 is the write side, index 1 the read side; in IDLE the live config is used so a start-cycle-0 access can fire immediately.
    always_comb begin
        idle    = state == IDLE;
        accept  = idle && bus.start;
        e0      = '{idle ? bus.cfg_wr_ext0 : sh_e0[0], idle ? bus.cfg_rd_ext0 : sh_e0[1]};
        e1      = '{idle ? bus.cfg_wr_ext1 : sh_e1[0], idle ? bus.cfg_rd_ext1 : sh_e1[1]};
        s0      = '{idle ? bus.cfg_wr_str0 : sh_s0[0], idle ? bus.cfg_rd_str0 : sh_s0[1]};
        s1      = '{idle ? bus.cfg_wr_str1 : sh_s1[0], idle ? bus.cfg_rd_str1 : sh_s1[1]};
        off     = '{idle ? bus.cfg_wr_off : sh_off[0], idle ? bus.cfg_rd_off : sh_off[1]};
        st      = '{idle ? bus.cfg_wr_start : sh_st[0], idle ? bus.cfg_rd_start : sh_st[1]};
        tn      = (t == T_MAX) ? t : t + CNT_W'(1);
        last    = '0;
        for (int s = 0; s < 2; s++)
            last[s] = act[s] && ci[s] == e0[s] - ADDR_W'(1) && cj[s] == e1[s] - ADDR_W'(1);
        fin_now = fin | last;
        state_d = idle ? (bus.start ? RUN : IDLE) : (state == RUN) ? (&fin_now ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (bus.clk_en)
            state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            t   <= '0;
            act <= '0;
            fin <= '0;
            for (int s = 0; s < 2; s++) begin
                ci[s]     <= '0;
                cj[s]     <= '0;
                addr[s]   <= '0;
                rbase[s]  <= '0;
                sh_e0[s]  <= '0;
                sh_e1[s]  <= '0;
                sh_s0[s]  <= '0;
                sh_s1[s]  <= '0;
                sh_off[s] <= '0;
                sh_st[s]  <= '0;
            end
        end else if (bus.clk_en) begin
            if (accept)
                t <= '0;
            else if (state == RUN)
                t <= tn;
            for (int s = 0; s < 2; s++) begin
                if (accept) begin
                    sh_e0[s]  <= e0[s];
                    sh_e1[s]  <= e1[s];
                    sh_s0[s]  <= s0[s];
                    sh_s1[s]  <= s1[s];
                    sh_off[s] <= off[s];
                    sh_st[s]  <= st[s];
                    ci[s]     <= '0;
                    cj[s]     <= '0;
                    fin[s]    <= e0[s] == '0 || e1[s] == '0;
                    act[s]    <= e0[s] != '0 && e1[s] != '0 && st[s] == '0;
                    if (e0[s] != '0 && e1[s] != '0 && st[s] == '0) begin
                        addr[s]  <= off[s] & MASK;
                        rbase[s] <= off[s] & MASK;
                    end
                end else if (state == RUN) begin
                    if (act[s]) begin
                        if (ci[s] == e0[s] - ADDR_W'(1)) begin
                            ci[s] <= '0;
                            if (cj[s] == e1[s] - ADDR_W'(1)) begin
                                act[s] <= 1'b0;
                                fin[s] <= 1'b1;
                            end else begin
                                cj[s]    <= cj[s] + ADDR_W'(1);
                                rbase[s] <= (rbase[s] + s1[s]) & MASK;
                                addr[s]  <= (rbase[s] + s1[s]) & MASK;
                            end
                        end else begin
                            ci[s]   <= ci[s] + ADDR_W'(1);
                            addr[s] <= (addr[s] + s0[s]) & MASK;
                        end
                    end else if (!fin[s] && tn == st[s]) begin
                        act[s]   <= 1'b1;
                        addr[s]  <= off[s] & MASK;
                        rbase[s] <= off[s] & MASK;
                    end
                end
            end
        end
    end
    // A stalled cycle must not present an enable the memory would miss; the access reissues once clk_en returns.
    assign wen              = act[0] && bus.clk_en;
    assign ren              = act[1] && bus.clk_en;
    assign bus.wen_0        = wen;
    assign bus.ren_0        = ren;
    assign bus.write_addr_0 = addr[0];
    assign bus.read_addr_0  = addr[1];
    assign bus.busy         = state == RUN;
    assign bus.done         = state == DONE && bus.clk_en;
`ifdef SREG_HAZARD_CHECK_EN
    localparam int OCC_W = $clog2(DEPTH) + 1;
    logic [OCC_W-1:0] occ;
    logic             herr;
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            herr <= 1'b0;
        end else if (bus.clk_en) begin
            if (accept) begin
                occ  <= '0;
                herr <= 1'b0;
            end else if (ren && !wen) begin
                if (occ == '0)
                    herr <= 1'b1;
                else
                    occ <= occ - OCC_W'(1);
            end else if (wen && !ren) begin
                if (occ == OCC_W'(DEPTH))
                    herr <= 1'b1;
                else
                    occ <= occ + OCC_W'(1);
            end
        end
    end
    assign bus.hazard_err = herr;
`else
    assign bus.hazard_err = 1'b0;
`endif
endmodule
